// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - engine result bus between Mandelbrot engines and the framebuffer write arbiter
interface fb_write_arbiter_if #(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_BITS   = 4
);
  logic [NUM_ENGINES-1:0]           res_valid;
  logic [NUM_ENGINES-1:0]           res_ready;
  logic [NUM_ENGINES*11-1:0]        res_x;
  logic [NUM_ENGINES*10-1:0]        res_y;
  logic [NUM_ENGINES*DATA_BITS-1:0] res_data;

  modport master (output res_valid, res_x, res_y, res_data, input res_ready);
  modport slave  (input res_valid, res_x, res_y, res_data, output res_ready);
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin merge of engine pixel results into framebuffer writes
module fb_write_arbiter #(
  parameter int NUM_ENGINES = 4,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 720,
  parameter int DATA_BITS   = 4,
  parameter int ADDR_BITS   = 2*$clog2(WIDTH-1)
) (
  input  logic                 clk_calc,
  input  logic                 reset_n,
  input  logic                 frame_start,
  fb_write_arbiter_if.slave    res,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_done,
  output logic                 coord_err
);
  localparam int GW     = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int CW     = $clog2(PIXELS + 1);
  localparam int XW_W   = $clog2(WIDTH + 1);
  // y*WIDTH+x fits in 12+XW_W bits; widen further if the address port is wider
  localparam int MW     = (ADDR_BITS > 12 + XW_W) ? ADDR_BITS : 12 + XW_W;

  logic [GW-1:0]          last_grant;
  logic [GW-1:0]          grant_idx;
  logic [GW:0]            cand;
  logic [NUM_ENGINES-1:0] grant;
  logic                   found;

  logic                   s1_valid;
  logic [10:0]            s1_x;
  logic [9:0]             s1_y;
  logic [DATA_BITS-1:0]   s1_data;
  logic                   s1_in_range;
  logic [MW-1:0]          full_addr;

  logic [CW-1:0]          frame_cnt;
  logic                   last_pixel;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_ENGINES; k++) begin
      cand = {1'b0, last_grant} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_ENGINES)) begin
        cand = cand - (GW+1)'(NUM_ENGINES);
      end
      if (!found && reset_n && res.res_valid[cand[GW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[GW-1:0];
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign res.res_ready = grant;

  assign s1_in_range = (int'(s1_x) < WIDTH) && (int'(s1_y) < HEIGHT);
  assign full_addr   = MW'(s1_y) * MW'(WIDTH) + MW'(s1_x);

  // A write coinciding with frame_start belongs to the new frame, so no done pulse then
  assign last_pixel = (frame_cnt == CW'(PIXELS - 1));
  assign frame_done = wr_en && last_pixel && !frame_start;

  always_ff @(posedge clk_calc or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GW'(NUM_ENGINES - 1);
      s1_valid   <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_data    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      coord_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      s1_valid <= found;
      if (found) begin
        last_grant <= grant_idx;
        s1_x       <= res.res_x[grant_idx*11 +: 11];
        s1_y       <= res.res_y[grant_idx*10 +: 10];
        s1_data    <= res.res_data[grant_idx*DATA_BITS +: DATA_BITS];
      end

      wr_en <= s1_valid && s1_in_range;
      if (s1_valid) begin
        wr_addr <= full_addr[ADDR_BITS-1:0];
        wr_data <= s1_data;
      end

      // A fresh out-of-range hit outranks the clear so it is never lost
      if (s1_valid && !s1_in_range) begin
        coord_err <= 1'b1;
      end else if (frame_start) begin
        coord_err <= 1'b0;
      end

      if (frame_start) begin
        frame_cnt <= wr_en ? CW'(1) : '0;
      end else if (wr_en) begin
        frame_cnt <= last_pixel ? '0 : frame_cnt + CW'(1);
      end
    end
  end
endmodule
